// File: rtl/ddr_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_arb_pkg
// Description : Shared widths, timeout default and FSM encoding for the
//               two-requester DDR write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_wr_arb_pkg;

    localparam int c_ADDR_W = 28;
    localparam int c_DATA_W = 256;
    localparam int c_LEN_W  = 4;
    localparam int c_TO_CYC = 4096;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_ISSUE = c_ST_ISSUE,
        ST_BUSY  = c_ST_BUSY,
        ST_DONE  = c_ST_DONE
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_wr_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin winner select; the pointer moves to the
//               other requester whenever a burst retires.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ddr_wr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    input  logic       i_adv_owner,
    output logic       o_win,
    output logic [1:0] o_win_oh,
    output logic       o_any
);

    logic r_ptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr <= 1'b0;
        end else if (i_adv) begin
            r_ptr <= ~i_adv_owner;
        end
    end

    // Pointer only matters on contention; a sole requester always wins.
    always_comb begin
        o_any    = |i_req;
        o_win    = (i_req == 2'b11) ? r_ptr : i_req[1];
        o_win_oh = onehot2(o_win);
    end

endmodule
`default_nettype wire

// File: rtl/ddr_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_arb
// Description : Round-robin arbiter for the DDR controller write handshake,
//               one burst in flight. Define DDR_WR_ARB_STAT_EN for burst and
//               timeout statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_wr_arb
    import ddr_wr_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int LEN_W  = c_LEN_W,
    parameter int TO_CYC = c_TO_CYC
) (
    input  logic              ddr_clk,
    input  logic              rstn,
    input  logic              ini_done,
    input  logic              req0,
    input  logic              req1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [1:0]        gnt,
    input  logic              wr_busy,
    input  logic              wr_done,
    output logic              wr_req,
    output logic [LEN_W-1:0]  awlen,
    output logic [ADDR_W-1:0] ddr_waddr,
    output logic [DATA_W-1:0] ddr_wdata
`ifdef DDR_WR_ARB_STAT_EN
    ,
    output logic [31:0]       bcnt0,
    output logic [31:0]       bcnt1,
    output logic [15:0]       tocnt
`endif
);

    localparam int                c_TO_W    = $clog2(TO_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TO_CYC - 1);

    state_t              r_state;
    logic                r_owner;
    logic [c_TO_W-1:0]   r_to_cnt;

    logic                w_win;
    logic [1:0]          w_win_oh;
    logic                w_any;
    logic                w_active;
    logic                w_fin_ok;
    logic                w_fin_to;

    rr_arb2 u_rr_arb2 (
        .clk         (ddr_clk),
        .rstn        (rstn),
        .i_req       ({req1, req0}),
        .i_adv       (r_state == ST_DONE),
        .i_adv_owner (r_owner),
        .o_win       (w_win),
        .o_win_oh    (w_win_oh),
        .o_any       (w_any)
    );

    // Completion beats timeout when both land on the same cycle.
    assign w_active = (r_state == ST_ISSUE) || (r_state == ST_BUSY);
    assign w_fin_ok = w_active && wr_done;
    assign w_fin_to = w_active && !wr_done && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge ddr_clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_to_cnt  <= '0;
            gnt       <= 2'b00;
            wr_req    <= 1'b0;
            awlen     <= '0;
            ddr_waddr <= '0;
            ddr_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (gnt != 2'b00) begin
                ddr_wdata <= r_owner ? data1 : data0;
            end

            if (w_fin_ok || w_fin_to) begin
                r_state <= ST_DONE;
                wr_req  <= 1'b0;
                gnt     <= 2'b00;
                ack0    <= ~r_owner;
                ack1    <= r_owner;
                err0    <= w_fin_to & ~r_owner;
                err1    <= w_fin_to & r_owner;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ini_done && w_any) begin
                            r_owner   <= w_win;
                            gnt       <= w_win_oh;
                            awlen     <= w_win ? len1 : len0;
                            ddr_waddr <= w_win ? addr1 : addr0;
                            r_to_cnt  <= '0;
                            r_state   <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        // Only a busy seen against our own request means acceptance.
                        if (wr_req && wr_busy) begin
                            wr_req  <= 1'b0;
                            r_state <= ST_BUSY;
                        end else begin
                            wr_req <= 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DDR_WR_ARB_STAT_EN
    always_ff @(posedge ddr_clk) begin
        if (!rstn) begin
            bcnt0 <= '0;
            bcnt1 <= '0;
            tocnt <= '0;
        end else if (r_state == ST_DONE) begin
            if (err0 || err1) begin
                if (tocnt != '1) tocnt <= tocnt + 1'b1;
            end else if (ack1) begin
                if (bcnt1 != '1) bcnt1 <= bcnt1 + 1'b1;
            end else begin
                if (bcnt0 != '1) bcnt0 <= bcnt0 + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_wr_arb
// Description : Directed self-checking bench for ddr_wr_arb with a scoreboard
//               of expected acks and a small DDR controller responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_arb;
    import ddr_wr_arb_pkg::*;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 4;
    localparam int TO_CYC = 16;
    localparam logic [DATA_W-1:0] c_D0 = {8{32'hA0A0_0001}};
    localparam logic [DATA_W-1:0] c_D1 = {8{32'hB1B1_0002}};

    logic              ddr_clk = 1'b0;
    logic              rstn = 1'b0;
    logic              ini_done = 1'b0;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [LEN_W-1:0]  len0 = '0;
    logic [LEN_W-1:0]  len1 = '0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [DATA_W-1:0] data0 = '0;
    logic [DATA_W-1:0] data1 = '0;
    logic              wr_busy = 1'b0;
    logic              wr_done = 1'b0;
    logic              ack0, ack1, err0, err1, wr_req;
    logic [1:0]        gnt;
    logic [LEN_W-1:0]  awlen;
    logic [ADDR_W-1:0] ddr_waddr;
    logic [DATA_W-1:0] ddr_wdata;
`ifdef DDR_WR_ARB_STAT_EN
    logic [31:0]       bcnt0, bcnt1;
    logic [15:0]       tocnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic              owner;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t m_e;

    // Controller responder knobs
    int m_st = 0;
    int m_cnt = 0;
    int m_busy_dly = 1;
    int m_done_dly = 3;
    bit m_nodone = 1'b0;
    bit m_fast = 1'b0;

    ddr_wr_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .TO_CYC (TO_CYC)
    ) dut (
        .ddr_clk   (ddr_clk),
        .rstn      (rstn),
        .ini_done  (ini_done),
        .req0      (req0),
        .req1      (req1),
        .len0      (len0),
        .len1      (len1),
        .addr0     (addr0),
        .addr1     (addr1),
        .data0     (data0),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err0      (err0),
        .err1      (err1),
        .gnt       (gnt),
        .wr_busy   (wr_busy),
        .wr_done   (wr_done),
        .wr_req    (wr_req),
        .awlen     (awlen),
        .ddr_waddr (ddr_waddr),
        .ddr_wdata (ddr_wdata)
`ifdef DDR_WR_ARB_STAT_EN
        ,
        .bcnt0     (bcnt0),
        .bcnt1     (bcnt1),
        .tocnt     (tocnt)
`endif
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic own, input logic er);
        exp_t e;
        e.owner = own;
        e.err   = er;
        e.addr  = own ? addr1 : addr0;
        e.len   = own ? len1 : len0;
        e.data  = own ? data1 : data0;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge ddr_clk);
            got = ack0 | ack1;
        end
        check("ack_wait", got, 1'b1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"},   gnt, 2'b00);
        check({tag, "_wrreq"}, wr_req, 1'b0);
        check({tag, "_ackerr"}, {ack1, ack0, err1, err0}, 4'b0000);
        check({tag, "_awlen"}, awlen, '0);
        check({tag, "_waddr"}, ddr_waddr, '0);
        check({tag, "_wdata"}, ddr_wdata, '0);
    endtask

    // DDR controller responder: busy after m_busy_dly, done m_done_dly later.
    always @(negedge ddr_clk) begin
        wr_done = 1'b0;
        if (!rstn || ack0 || ack1) begin
            m_st    = 0;
            m_cnt   = 0;
            wr_busy = 1'b0;
        end else begin
            case (m_st)
                0: if (wr_req) begin
                    m_cnt = 1;
                    m_st  = 1;
                end
                1: if (m_cnt >= m_busy_dly) begin
                    if (m_fast) begin
                        wr_done = 1'b1;
                        m_st    = 0;
                    end else begin
                        wr_busy = 1'b1;
                        m_cnt   = 0;
                        m_st    = 2;
                    end
                end else begin
                    m_cnt++;
                end
                default: begin
                    m_cnt++;
                    if (!m_nodone && m_cnt >= m_done_dly) begin
                        wr_done = 1'b1;
                        wr_busy = 1'b0;
                        m_st    = 0;
                    end
                end
            endcase
        end
    end

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge ddr_clk) begin
        if (ack0 || ack1) begin
            if (sb_q.size() == 0) begin
                check("ack_unexpected", {ack1, ack0}, 2'b00);
            end else begin
                m_e = sb_q.pop_front();
                check("ack_owner", {ack1, ack0}, m_e.owner ? 2'b10 : 2'b01);
                check("ack_err", {err1, err0}, m_e.err ? (m_e.owner ? 2'b10 : 2'b01) : 2'b00);
                check("ack_gnt", gnt, 2'b00);
                check("ack_waddr", ddr_waddr, m_e.addr);
                check("ack_awlen", awlen, m_e.len);
                check("ack_wdata", ddr_wdata, m_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       busy_seen;
        logic [31:0] b_before;
        addr0 = 28'h0001000;
        len0  = 4'd7;
        data0 = c_D0;
        addr1 = 28'h0A00040;
        len1  = 4'd3;
        data1 = c_D1;
        ini_done = 1'b1;
        rstn = 1'b0;
        b_before = '0;

        // Reset state
        repeat (3) @(negedge ddr_clk);
        check_cleared("rst");
        @(negedge ddr_clk);
        rstn = 1'b1;
        @(negedge ddr_clk);

        // Single request from requester 0
        m_busy_dly = 3;
        m_done_dly = 10;
        req0 = 1'b1;
        push(1'b0, 1'b0);
        @(negedge ddr_clk);
        check("single_lat1_wrreq", wr_req, 1'b0);
        check("single_gnt", gnt, 2'b01);
        @(negedge ddr_clk);
        check("single_lat2_wrreq", wr_req, 1'b1);
        check("single_waddr", ddr_waddr, 28'h0001000);
        check("single_awlen", awlen, 4'd7);
        check("single_wdata", ddr_wdata, c_D0);
        wait_ack(40);
        req0 = 1'b0;
        check("single_gnt_idle", gnt, 2'b00);
        @(negedge ddr_clk);

        // Reset while the burst sits in BUSY
        m_busy_dly = 1;
        m_nodone = 1'b1;
        req0 = 1'b1;
        repeat (4) @(negedge ddr_clk);
        check("midrst_busy_gnt", gnt, 2'b01);
        check("midrst_busy_wrreq", wr_req, 1'b0);
        @(negedge ddr_clk);
        rstn = 1'b0;
        req0 = 1'b0;
        @(negedge ddr_clk);
        check_cleared("midrst");
        @(negedge ddr_clk);
        rstn = 1'b1;
        m_nodone = 1'b0;
        m_done_dly = 3;
        @(negedge ddr_clk);

        // Contention after reset: pointer starts at requester 0
        req0 = 1'b1;
        req1 = 1'b1;
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        repeat (4) wait_ack(30);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge ddr_clk);

        // Fast path: wr_done while still in ISSUE
        m_fast = 1'b1;
        m_busy_dly = 2;
`ifdef DDR_WR_ARB_STAT_EN
        b_before = bcnt0;
`endif
        req0 = 1'b1;
        push(1'b0, 1'b0);
        wait_ack(30);
        req0 = 1'b0;
        @(negedge ddr_clk);
        m_fast = 1'b0;
        m_busy_dly = 1;
`ifdef DDR_WR_ARB_STAT_EN
        check("fast_bcnt0", bcnt0, b_before + 32'd1);
`endif

        // Timeout on requester 1, then pointer must favour requester 0
        m_nodone = 1'b1;
        req1 = 1'b1;
        push(1'b1, 1'b1);
        @(negedge ddr_clk);
        check("to_gnt", gnt, 2'b10);
        repeat (15) @(negedge ddr_clk);
        check("to_early_ack1", ack1, 1'b0);
        @(negedge ddr_clk);
        check("to_ack1", ack1, 1'b1);
        check("to_err1", err1, 1'b1);
        check("to_wrreq", wr_req, 1'b0);
        m_nodone = 1'b0;
        m_done_dly = 3;
        req0 = 1'b1;
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        wait_ack(30);
        req0 = 1'b0;
        wait_ack(30);
        req1 = 1'b0;
        @(negedge ddr_clk);

        // Calibration gating
        ini_done = 1'b0;
        req0 = 1'b1;
        push(1'b0, 1'b0);
        busy_seen = 1'b0;
        repeat (50) begin
            @(negedge ddr_clk);
            if (wr_req || gnt != 2'b00) busy_seen = 1'b1;
        end
        check("gate_quiet", busy_seen, 1'b0);
        ini_done = 1'b1;
        @(negedge ddr_clk);
        check("gate_lat1_wrreq", wr_req, 1'b0);
        @(negedge ddr_clk);
        check("gate_lat2_wrreq", wr_req, 1'b1);
        wait_ack(40);
        req0 = 1'b0;
        repeat (3) @(negedge ddr_clk);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_wr_arb.md
Name: ddr_wr_arb

Overview:
- Two-requester arbiter for the single DDR write-port handshake: wr_req / awlen / ddr_waddr / ddr_wdata / wr_busy / wr_done.
- Requester 0 is the HDMI input frame writer. Requester 1 is the processed-image / overlay writer.
- Round-robin grant; one burst in flight at a time.
- Sits between the writers and the DDR controller write channel, entirely in the ddr_clk domain.

Parameters:
- ADDR_W, 28, DDR controller address width (matches CTRL_ADDR_WIDTH).
- DATA_W, 256, write data width (MEM_DQ_WIDTH*8).
- LEN_W, 4, burst length field width (awlen).
- TO_CYC, 4096, cycles without wr_done before a burst is aborted.

Ports:
- ddr_clk  in  1  sole clock
- rstn  in  1  synchronous active-low reset
- ini_done  in  1  DDR calibration done; no grant while low
- req0 / req1  in  1  write request; held high until matching ack
- len0 / len1  in  LEN_W  burst length; stable while req high
- addr0 / addr1  in  ADDR_W  burst start address; stable while req high
- data0 / data1  in  DATA_W  write data from requester
- ack0 / ack1  out  1  one-cycle pulse: burst complete or aborted
- err0 / err1  out  1  valid with ack; 1 = aborted by timeout
- gnt  out  2  one-hot current owner; 00 when idle
- wr_busy  in  1  controller accepted request / burst in progress
- wr_done  in  1  controller burst complete (one-cycle pulse)
- wr_req  out  1  request to controller
- awlen  out  LEN_W  registered burst length
- ddr_waddr  out  ADDR_W  registered address
- ddr_wdata  out  DATA_W  registered data of granted requester

Behaviour:
- Reset (rstn low at a ddr_clk edge): state IDLE; all outputs 0; rr pointer = 0 (requester 0 preferred).
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - if ini_done and any req: pick the winner, latch len/addr into awlen/ddr_waddr, set gnt, go ISSUE.
  - Winner: if both req, rr pointer wins; else the sole requester.
- ISSUE: wr_req=1.
  - wr_busy=1 → wr_req=0 next cycle, go BUSY.
  - wr_done seen in ISSUE (controller fast path) → go DONE directly.
- BUSY: wait for wr_done → DONE.
- DONE: for exactly one cycle:
  - ack of owner = 1, err = 0, gnt = 00.
  - rr pointer = other requester.
  - Next state IDLE, so minimum gap between bursts is 1 idle cycle.
- Latency: req high → wr_req high = 2 cycles (IDLE latch, ISSUE drive).
- ddr_wdata: each cycle while gnt≠00, register data of the owner; otherwise hold last value. The requester supplies beat data in step with the controller.
- Timeout:
  - A cycle counter runs in ISSUE and BUSY and clears on entering ISSUE.
  - Reaching TO_CYC → DONE with err=1 and wr_req dropped.
  - The rr pointer still rotates.
- Requester drops req before ack: protocol violation; the burst still completes and ack still pulses.
- ini_done falls mid-burst: current burst completes normally; no new grant until ini_done returns.
- rstn low mid-burst: immediate return to IDLE next edge, outputs cleared, no ack.
- wr_done outside ISSUE/BUSY: ignored.

Optional Feature:
- Macro: DDR_WR_ARB_STAT_EN.
- When defined, adds outputs:
  - bcnt0 / bcnt1 (32 bits): completed-burst counters per requester, increment in DONE when err=0, saturate at all ones.
  - tocnt (16 bits): total timeouts, saturating.
  - All clear on reset.
- When undefined: ports and counters absent; the remaining behaviour is identical.

Decomposition:
- Shared package/header holds:
  - ADDR_W, DATA_W and LEN_W defaults.
  - State encoding constants: IDLE=0, ISSUE=1, BUSY=2, DONE=3.
  - TO_CYC default.
- One natural sub-module: rr_arb2, a 2-way round-robin winner select with pointer update. Everything else stays in the top.

Test Plan:
- Single request:
  - Stimulus: req0=1, addr0=0x0001000, len0=7; model asserts wr_busy 3 cycles after wr_req, wr_done 10 cycles later.
  - Required: wr_req high 2 cycles after req0; ddr_waddr=0x0001000; awlen=7; ack0 one pulse; err0=0; gnt back to 00.
- Simultaneous requests after reset:
  - Stimulus: req0 and req1 both held.
  - Required: grant order 0,1,0,1 over 4 bursts; each ack matches its owner.
- Timeout:
  - Stimulus: TO_CYC=16; wr_busy asserted, wr_done never arrives.
  - Required: ack1 and err1 pulse at cycle 16 after ISSUE entry; wr_req low; next grant goes to requester 0.
- Calibration gating:
  - Stimulus: ini_done=0 with req0=1 for 50 cycles, then ini_done=1.
  - Required: no wr_req during the 50 cycles; wr_req 2 cycles after ini_done rises.
- Reset mid-burst:
  - Stimulus: rstn low while in BUSY.
  - Required: next edge all outputs 0, no ack; later req1 served first-come, with rr pointer at 0.
- Fast path (DDR_WR_ARB_STAT_EN builds):
  - Stimulus: wr_done during ISSUE.
  - Required: DONE reached, ack asserted, bcnt incremented by 1.
